// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, S-box, GF(2^8) helpers, rcon and key-schedule step.
package aes_pkg;
  localparam int NR = 10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

  // Element 0 sits at the MSB end, so SBOX[x] is the usual table lookup.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:15][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    return RCON[r];
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction
endpackage

// File: rtl/aes_enc_core_if.sv
// Plaintext/key input and ciphertext output handshakes of the AES encryption core.
interface aes_enc_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (output in_valid, in_data, key, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, key, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_enc_round.sv
// One combinational AES forward round: SubBytes, ShiftRows, MixColumns (skipped when final), AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rkey,
  input  logic         i_final,
  output logic [127:0] o_state
);
  logic [0:15][7:0] w_in, w_sr, w_mc;

  assign w_in = i_state;

  // Byte i is row i%4, column i/4; ShiftRows pulls row r from column (c+r)%4.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int R = i % 4;
    localparam int C = i / 4;
    assign w_sr[i] = sbox(w_in[R + 4 * ((C + R) % 4)]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = w_sr[4*c];
    assign a1 = w_sr[4*c+1];
    assign a2 = w_sr[4*c+2];
    assign a3 = w_sr[4*c+3];
    assign w_mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign w_mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign w_mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign w_mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign o_state = (i_final ? w_sr : w_mc) ^ i_rkey;
endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES-128 encryption core, round keys expanded on the fly.
// AES_ENC_2RPC_EN: chains two round instances so each RUN cycle completes two rounds.
module aes_enc_core
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  aes_enc_core_if.slave   bus
);
  fsm_e         r_fsm, w_fsm_nxt;
  logic [127:0] r_state, r_rkey, w_state_nxt, w_rkey_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic         r_out_valid;

  logic [127:0] w_rk1, w_st1, w_step_state, w_step_rkey;
  logic [3:0]   w_step_round;
  logic         w_last;

  assign w_rk1 = key_step(r_rkey, rcon(r_round));

  aes_enc_round u_rnd0 (
    .i_state (r_state),
    .i_rkey  (w_rk1),
    .i_final (r_round == 4'(NR)),
    .o_state (w_st1)
  );

`ifdef AES_ENC_2RPC_EN
  logic [127:0] w_rk2, w_st2;
  logic [3:0]   w_round2;

  assign w_round2 = r_round + 4'd1;
  assign w_rk2    = key_step(w_rk1, rcon(w_round2));

  aes_enc_round u_rnd1 (
    .i_state (w_st1),
    .i_rkey  (w_rk2),
    .i_final (w_round2 == 4'(NR)),
    .o_state (w_st2)
  );

  assign w_step_state = w_st2;
  assign w_step_rkey  = w_rk2;
  assign w_step_round = r_round + 4'd2;
  assign w_last       = (w_round2 == 4'(NR));
`else
  assign w_step_state = w_st1;
  assign w_step_rkey  = w_rk1;
  assign w_step_round = r_round + 4'd1;
  assign w_last       = (r_round == 4'(NR));
`endif

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_rkey_nxt  = r_rkey;
    w_round_nxt = r_round;
    case (r_fsm)
      S_IDLE: if (bus.in_valid) begin
        w_state_nxt = bus.in_data ^ bus.key;
        w_rkey_nxt  = bus.key;
        w_round_nxt = 4'd1;
        w_fsm_nxt   = S_RUN;
      end
      S_RUN: begin
        w_state_nxt = w_step_state;
        w_rkey_nxt  = w_step_rkey;
        // Counter parks at 0 once the last round lands so it never passes NR.
        w_round_nxt = w_last ? 4'd0 : w_step_round;
        if (w_last) w_fsm_nxt = S_DONE;
      end
      S_DONE: if (bus.out_ready) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_rkey      <= '0;
      r_round     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state     <= w_state_nxt;
      r_rkey      <= w_rkey_nxt;
      r_round     <= w_round_nxt;
      r_out_valid <= (w_fsm_nxt == S_DONE);
    end
  end

  assign bus.in_ready  = (r_fsm == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_state;
endmodule

// File: tb/tb_aes_enc_core.sv
// Directed-vector bench for aes_enc_core: known-answer table plus handshake corner sequences.
module tb_aes_enc_core;
`ifdef AES_ENC_2RPC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 10;
`endif

  typedef struct {
    string        name;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[4];

  always #5 clk = ~clk;

  aes_enc_core_if u_if ();

  aes_enc_core u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one block, measure latency, check ciphertext and the handoff back to IDLE.
  task automatic encrypt(input vec_t v, input bit scramble);
    int  n;
    bit  got;
    n = -1;
    got = 0;
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.in_data  = v.pt;
    u_if.key      = v.key;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    if (scramble) begin
      u_if.in_data = ~v.pt;
      u_if.key     = v.key ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
    end
    chk({v.name, " in_ready in RUN"}, 128'(u_if.in_ready), 128'(0));
    for (int c = 1; c <= LAT + 4; c++) begin
      if (!got) begin
        @(posedge clk); #1;
        if (u_if.out_valid) begin
          got = 1;
          n = c;
        end
      end
    end
    chk({v.name, " latency"}, 128'(n), 128'(LAT));
    chk({v.name, " ciphertext"}, u_if.out_data, v.ct);
    chk({v.name, " in_ready in DONE"}, 128'(u_if.in_ready), 128'(0));
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
    chk({v.name, " handoff idle"}, 128'({u_if.out_valid, u_if.in_ready}), 128'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int           n;
    bit           got;
    bit           pend;
    int           acc[2];
    logic [127:0] outs[2];
    int           na, no;

    vecs[0] = '{"appB", 128'h3243f6a8885a308d313198a2e0370734,
                128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{"appC1", 128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{"zeros", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[3] = '{"vartxt0", 128'h80000000000000000000000000000000,
                128'h0, 128'h3ad78e726c1ec02b7ebfe92b23d9ec34};

    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.key       = '0;
    u_if.out_ready = 1'b0;

    #1;
    chk("reset out_data", u_if.out_data, 128'h0);
    chk("reset flags", 128'({u_if.out_valid, u_if.in_ready}), 128'(2'b01));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) encrypt(vecs[i], 1'b0);

    // Inputs scrambled right after acceptance must not disturb the block.
    encrypt(vecs[0], 1'b1);

    // Backpressure: DONE held 20 cycles while in_valid pulses are ignored.
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.in_data  = vecs[1].pt;
    u_if.key      = vecs[1].key;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      if (!got) begin
        @(posedge clk); #1;
        got = u_if.out_valid;
      end
    end
    chk("bp out_valid seen", 128'(got), 128'(1));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      u_if.in_valid = c[0];
      u_if.in_data  = vecs[0].pt;
      u_if.key      = vecs[0].key;
      @(posedge clk); #1;
      chk("bp out_data held", u_if.out_data, vecs[1].ct);
      chk("bp flags held", 128'({u_if.out_valid, u_if.in_ready}), 128'(2'b10));
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
    chk("bp release idle", 128'({u_if.out_valid, u_if.in_ready}), 128'(2'b01));

    // Back-to-back: in_valid held high, out_ready held high.
    na = 0;
    no = 0;
    acc[0] = 0; acc[1] = 0;
    outs[0] = '0; outs[1] = '0;
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b1;
    u_if.in_data  = vecs[0].pt;
    u_if.key      = vecs[0].key;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (no < 2) begin
        @(negedge clk);
        pend = u_if.in_ready && u_if.in_valid;
        if (u_if.out_valid) begin
          outs[no] = u_if.out_data;
          no++;
        end
        @(posedge clk); #1;
        if (pend && na < 2) begin
          acc[na] = cyc;
          na++;
          if (na == 1) begin
            u_if.in_data = vecs[1].pt;
            u_if.key     = vecs[1].key;
          end else begin
            u_if.in_valid = 1'b0;
          end
        end
      end
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    chk("b2b acceptances", 128'(na), 128'(2));
    chk("b2b interval", 128'(acc[1] - acc[0]), 128'(LAT + 2));
    chk("b2b first ct", outs[0], vecs[0].ct);
    chk("b2b second ct", outs[1], vecs[1].ct);

    // Reset mid-block aborts immediately; a fresh block then encrypts normally.
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.in_data  = vecs[0].pt;
    u_if.key      = vecs[0].key;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_data", u_if.out_data, 128'h0);
    chk("midrst flags", 128'({u_if.out_valid, u_if.in_ready}), 128'(2'b01));
    @(posedge clk); #1;
    chk("midrst flags held", 128'({u_if.out_valid, u_if.in_ready}), 128'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    encrypt(vecs[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/aes_enc_core.md
# aes_enc_core

Iterative AES-128 encryption core: accepts a 128-bit plaintext block and 128-bit key over a valid/ready handshake and runs one forward round per clock. Round keys are expanded on the fly. The ciphertext is held on a valid/ready output port until it is taken. It is the transmit-side counterpart of the decryption datapath and produces ciphertext that the inverse rounds recover.

## Interface
Parameters: none.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  plaintext/key present.
- in_ready  output  1  core can accept a block.
- in_data  input  128  plaintext. Bits [127:120] are state byte 0. Bytes fill the state column-major.
- key  input  128  cipher key, same byte order as in_data. Sampled only on acceptance.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer takes ciphertext.
- out_data  output  128  ciphertext, same byte order as in_data.

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: state_reg <= in_data ^ key, rkey_reg <= key, round <= 1, go to RUN.
- RUN, each cycle:
  - rkey_next = expand(rkey_reg, rcon[round]).
  - state_reg <= round_fn(state_reg, rkey_next), rkey_reg <= rkey_next, round <= round+1.
  - round_fn applies SubBytes, ShiftRows, MixColumns and AddRoundKey. MixColumns is skipped when round==10.
  - After round 10 is computed, go to DONE.
- DONE:
  - out_valid=1, out_data=state_reg, both held stable until out_ready.
  - On out_ready: go to IDLE.
- in_ready=0 in RUN and DONE. A new block is not accepted in the same cycle the output is taken.
- Key expansion: w4i = w4(i-1) ^ SubWord(RotWord(w4i-1+3)) ^ {rcon,24'h0}. Remaining words are chained XOR.
- rcon = 01,02,04,08,10,20,40,80,1b,36 for rounds 1–10.
- round is a 4-bit counter and never exceeds 10.
- in_valid is ignored outside IDLE. in_data and key may change freely after acceptance.
- out_ready is ignored outside DONE.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - FSM=IDLE, round=0.
  - state_reg=0, rkey_reg=0, so out_data=0.
  - in_ready=1, out_valid=0.
- Reset asserted mid-RUN or in DONE aborts the block immediately. No output is produced.
- Latency: acceptance at edge N gives out_valid=1 after edge N+10 (one round per cycle).
- Minimum initiation interval: 12 cycles (accept, 10 rounds, handoff with out_ready=1 in the first DONE cycle, back to IDLE).
- out_valid and out_data are registered. in_ready is decoded from the FSM state only, with no combinational path from out_ready.
- Backpressure: out_ready held low keeps DONE indefinitely with out_data stable.

## Configuration
- AES_ENC_2RPC_EN:
  - Defined: two aes_enc_round instances are chained, so RUN computes rounds r and r+1 per cycle. Round advances by 2, the second instance does the final round on the last step, and rounds 9–10 finish at edge N+5.
  - Latency becomes 5 cycles. Minimum interval becomes 7 cycles.
  - Undefined: single instance, 10-cycle latency as above.
  - The port list is identical in both builds.

## Structure
- aes_pkg holds:
  - FSM state enum.
  - 256-entry S-box constant and sbox() function.
  - xtime() function.
  - rcon table.
  - Key-expansion step function.
  - Localparam NR=10.
- Sub-module aes_enc_round (combinational): inputs state, round key and a final flag; output is the next state. It owns SubBytes, ShiftRows, MixColumns and AddRoundKey.
- aes_enc_core owns the FSM, counter, registers, key-expansion step and handshake.

## Test plan
- FIPS-197 App. B: in_data=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> out_data=3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after acceptance (5 with AES_ENC_2RPC_EN).
- FIPS-197 App. C.1: in_data=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data constant, in_ready=0, extra in_valid pulses ignored. Release -> IDLE next cycle with in_ready=1.
- Back-to-back: App. B then App. C.1 with in_valid held high and out_ready=1 -> both correct ciphertexts in order, acceptances 12 cycles apart.
- Reset mid-block: assert rst_n=0 at round 5 -> out_valid=0, out_data=0, in_ready=1 immediately. A fresh App. B block then encrypts correctly.
- Key change after acceptance: alter key and in_data the cycle after acceptance -> ciphertext still matches the originally accepted block.
